// File: rtl/dmem_port_arbiter_pkg.sv
// Shared widths and FSM state encoding for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int ADDR_LEN    = 32;
  localparam int DATA_LEN    = 32;
  localparam int RRF_SEL     = 6;
  localparam int SPECTAG_LEN = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_port_arbiter_ld_spec_track.sv
// Speculation tracking for the single in-flight load: latches its branch tag and
// records whether a mispredict has killed it before completion.
module dmem_port_arbiter_ld_spec_track
  import dmem_port_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture,
  input  logic                   active,
  input  logic                   ld_specbit,
  input  logic [SPECTAG_LEN-1:0] ld_spectag,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] spectagfix,
  output logic                   killed
);

  logic                   specbit;
  logic [SPECTAG_LEN-1:0] spectag;
  logic                   kill_new;
  logic                   clr_new;
  logic                   kill_held;
  logic                   clr_held;

  // Accept cycle uses the incoming tag; later cycles use the latched one.
  assign kill_new  = prmiss && ld_specbit && (|(spectagfix & ld_spectag));
  assign clr_new   = prsuccess && (prtag == ld_spectag);
  assign kill_held = prmiss && specbit && (|(spectagfix & spectag));
  assign clr_held  = prsuccess && (prtag == spectag);

  always_ff @(posedge clk) begin
    if (!reset) begin
      specbit <= 1'b0;
      spectag <= '0;
      killed  <= 1'b0;
    end else if (capture) begin
      spectag <= ld_spectag;
      specbit <= ld_specbit && !clr_new;
      killed  <= kill_new;
    end else if (active) begin
      if (kill_held) begin
        killed <= 1'b1;
      end else if (clr_held) begin
        specbit <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Owns the single-port dmem, muxing retired stores and one outstanding load.
// Define STBUF_FWD_EN to complete store-buffer hits without a memory read.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stretire,
  input  logic [ADDR_LEN-1:0]    retaddr,
  input  logic [DATA_LEN-1:0]    retdata,
  output logic                   memoccupy_ld,
  input  logic                   ld_req,
  output logic                   ld_ready,
  input  logic [ADDR_LEN-1:0]    ld_addr,
  input  logic [RRF_SEL-1:0]     ld_tag,
  input  logic                   ld_specbit,
  input  logic [SPECTAG_LEN-1:0] ld_spectag,
  input  logic                   sb_hit,
  input  logic [DATA_LEN-1:0]    sb_lddata,
  input  logic                   sb_empty,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] spectagfix,
  output logic [ADDR_LEN-1:0]    mem_addr,
  output logic [DATA_LEN-1:0]    mem_wdata,
  output logic                   mem_we,
  output logic                   mem_re,
  input  logic [DATA_LEN-1:0]    mem_rdata,
  output logic                   ld_done,
  output logic [DATA_LEN-1:0]    ld_data,
  output logic [RRF_SEL-1:0]     ld_tag_out
);

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;
  logic             fwd;
  logic             killed;
  logic             rd_valid;

`ifdef STBUF_FWD_EN
  logic unused_empty;
  assign unused_empty = sb_empty;
  assign ld_ready     = (state == ST_IDLE);
  assign fwd          = sb_hit;
`else
  logic unused_hit;
  assign unused_hit = sb_hit;
  assign ld_ready   = (state == ST_IDLE) && sb_empty;
  assign fwd        = 1'b0;
`endif

  assign accept       = ld_req && ld_ready;
  assign rd_valid     = (state == ST_WAIT) && (cnt == CNT_LAST);
  // Driven only from ld_req and state so the store buffer's retire decision cannot loop back.
  assign memoccupy_ld = ld_req || (state == ST_WAIT);

  assign mem_re    = accept && !fwd;
  assign mem_addr  = mem_re ? ld_addr : retaddr;
  assign mem_wdata = retdata;
  assign mem_we    = stretire;

  assign ld_done = (state == ST_RESP) && !killed;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = fwd ? ST_RESP : ST_WAIT;
          cnt_nxt   = fwd ? '0 : CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = ST_RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ld_data    <= '0;
      ld_tag_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) ld_tag_out <= ld_tag;
      if (accept && fwd) ld_data <= sb_lddata;
      else if (rd_valid) ld_data <= mem_rdata;
    end
  end

  dmem_port_arbiter_ld_spec_track u_spec_track (
    .clk        (clk),
    .reset      (reset),
    .capture    (accept),
    .active     (state != ST_IDLE),
    .ld_specbit (ld_specbit),
    .ld_spectag (ld_spectag),
    .prmiss     (prmiss),
    .prsuccess  (prsuccess),
    .prtag      (prtag),
    .spectagfix (spectagfix),
    .killed     (killed)
  );

  a_no_store_during_load: assert property (@(posedge clk) disable iff (!reset)
    !(stretire && memoccupy_ld));

endmodule
